// File: rtl/mult_seq_pkg.sv
// Shared types and default sizes for the multiplier operand sequencer.
package mult_seq_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ACC_W = 10;
  localparam int PROD_W    = 2 * DEF_W;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/mult_operand_fifo.sv
// Small synchronous FIFO holding {last, a, b} operand pairs.
// Head entry is visible combinationally on pop_data while not empty.
module mult_operand_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mult_operand_sequencer.sv
// Streams operand pairs into a start/done sequential multiplier and
// returns each product with a running group sum on a valid/ready port.
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_product,
  input  logic             mul_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_product,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_last,
  output logic             out_ovf
);

  state_t             state;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [2*W:0]       head;
  logic               last_q;
  logic               done_q;
  logic               done_edge;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [ACC_W:0]     sum_ext;

  mult_operand_fifo #(
    .DW    (2*W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_last, in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  // A done level held over from the previous operation must not complete this one.
  assign done_edge = mul_done && !done_q;
  assign sum_ext   = {1'b0, acc} + (ACC_W+1)'(mul_product);
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      acc         <= '0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_sum     <= '0;
      out_last    <= 1'b0;
    end else begin
      done_q <= mul_done;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            last_q    <= head[2*W];
            mul_a     <= head[2*W-1:W];
            mul_b     <= head[W-1:0];
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (done_edge) begin
            out_product <= mul_product;
            acc         <= sum_ext[ACC_W-1:0];
            out_sum     <= sum_ext[ACC_W-1:0];
            ovf         <= ovf | sum_ext[ACC_W];
            out_last    <= last_q;
            out_valid   <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          // The group boundary resets the running sum once the last beat is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              acc <= '0;
              ovf <= 1'b0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural multiplier stand-in.
module tb_mult_operand_sequencer;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_product;
  logic       mul_done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic [9:0] out_sum;
  logic       out_last;
  logic       out_ovf;

  int errors = 0;
  int checks = 0;

  // multiplier stand-in controls and observation
  bit         stall = 1'b0;
  bit         stale_mode = 1'b0;
  bit         pulse_mode = 1'b0;
  int         mcount = 0;
  int         start_count = 0;
  logic [7:0] pa = '0;
  logic [7:0] pb = '0;

  mult_operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_sum     (out_sum),
    .out_last    (out_last),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  // In stale mode done stays high after start and only drops just before the fresh edge.
  always @(negedge clk) begin
    if (!reset) begin
      mcount   = 0;
      mul_done = 1'b0;
    end else if (mul_start) begin
      pa = {4'b0, mul_a};
      pb = {4'b0, mul_b};
      start_count++;
      if (!stale_mode) mul_done = 1'b0;
      mcount = LAT;
    end else if (mcount > 0 && !stall) begin
      mcount--;
      if (mcount == 1) mul_done = 1'b0;
      if (mcount == 0) begin
        mul_done    = 1'b1;
        mul_product = pa * pb;
      end
    end else if (pulse_mode && mul_done) begin
      mul_done = 1'b0;
    end
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b, input logic last,
                           output bit ok);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    ok       = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_start: got %b expected 0", mul_start); end
    checks++; if (out_sum !== 10'd0) begin errors++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    bit got;
    int base;
    base = start_count;
    push_pair(4'd3, 4'd5, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_push: got timeout expected accept"); end
    wait_valid(got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL basic_valid: got timeout expected out_valid"); end
    checks++; if (start_count - base !== 1) begin errors++; $display("[TB] FAIL basic_starts: got %0d expected 1", start_count - base); end
    checks++; if (pa !== 8'd3 || pb !== 8'd5) begin errors++; $display("[TB] FAIL basic_operands: got %0d,%0d expected 3,5", pa, pb); end
    checks++; if (out_product !== 8'd15) begin errors++; $display("[TB] FAIL basic_product: got %0d expected 15", out_product); end
    checks++; if (out_sum !== 10'd15) begin errors++; $display("[TB] FAIL basic_sum: got %0d expected 15", out_sum); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL basic_last: got %b expected 1", out_last); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", out_ovf); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_group_sum;
    bit ok;
    bit got;
    logic [3:0] va[4] = '{4'd15, 4'd10, 4'd2, 4'd1};
    logic [3:0] vb[4] = '{4'd15, 4'd0, 4'd7, 4'd1};
    logic       vl[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int         ep[4] = '{225, 0, 14, 1};
    int         es[4] = '{225, 225, 239, 1};
    for (int i = 0; i < 4; i++) begin
      push_pair(va[i], vb[i], vl[i], ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL group_push%0d: got timeout expected accept", i); end
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL group_valid%0d: got timeout expected out_valid", i); end
      checks++; if (out_product !== 8'(ep[i])) begin errors++; $display("[TB] FAIL group_product%0d: got %0d expected %0d", i, out_product, ep[i]); end
      checks++; if (out_sum !== 10'(es[i])) begin errors++; $display("[TB] FAIL group_sum%0d: got %0d expected %0d", i, out_sum, es[i]); end
      checks++; if (out_last !== vl[i]) begin errors++; $display("[TB] FAIL group_last%0d: got %b expected %b", i, out_last, vl[i]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
  endtask

  task automatic test_overflow;
    bit ok;
    bit got;
    int   es[6] = '{225, 450, 675, 900, 101, 1};
    logic eo[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic el[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pulse_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_pair(4'd15, 4'd15, el[i], ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_push%0d: got timeout expected accept", i); end
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        push_pair(4'd1, 4'd1, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_push5: got timeout expected accept"); end
      end
      wait_valid(got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL ovf_valid%0d: got timeout expected out_valid", i); end
      checks++; if (out_sum !== 10'(es[i])) begin errors++; $display("[TB] FAIL ovf_sum%0d: got %0d expected %0d", i, out_sum, es[i]); end
      checks++; if (out_ovf !== eo[i]) begin errors++; $display("[TB] FAIL ovf_flag%0d: got %b expected %b", i, out_ovf, eo[i]); end
      checks++; if (out_last !== el[i]) begin errors++; $display("[TB] FAIL ovf_last%0d: got %b expected %b", i, out_last, el[i]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
    pulse_mode = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit got;
    int base;
    int hold_bad;
    logic [3:0] va[5] = '{4'd1, 4'd3, 4'd2, 4'd4, 4'd7};
    logic [3:0] vb[5] = '{4'd2, 4'd3, 4'd5, 4'd4, 4'd2};
    int         ep[5] = '{2, 9, 10, 16, 14};
    int         es[5] = '{2, 11, 21, 37, 51};
    stall = 1'b1;
    base  = start_count;
    for (int i = 0; i < 5; i++) begin
      push_pair(va[i], vb[i], (i == 4), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_push%0d: got timeout expected accept", i); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full: got in_ready=%b expected 0", in_ready); end
    checks++; if (start_count - base !== 1) begin errors++; $display("[TB] FAIL bp_starts: got %0d expected 1", start_count - base); end
    stall = 1'b0;
    wait_valid(got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL bp_valid0: got timeout expected out_valid"); end
    hold_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_product !== 8'd2 || out_sum !== 10'd2 ||
          start_count - base !== 1 || in_ready !== 1'b0)
        hold_bad++;
    end
    checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_valid(got);
        checks++; if (!got) begin errors++; $display("[TB] FAIL bp_valid%0d: got timeout expected out_valid", i); end
      end
      checks++; if (out_product !== 8'(ep[i])) begin errors++; $display("[TB] FAIL bp_product%0d: got %0d expected %0d", i, out_product, ep[i]); end
      checks++; if (out_sum !== 10'(es[i])) begin errors++; $display("[TB] FAIL bp_sum%0d: got %0d expected %0d", i, out_sum, es[i]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
  endtask

  task automatic test_stale_done;
    bit ok;
    bit got;
    int spurious;
    stale_mode = 1'b1;
    push_pair(4'd6, 4'd7, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_push: got timeout expected accept"); end
    for (int i = 0; i < 50 && !mul_start; i++) @(negedge clk);
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("[TB] FAIL stale_spurious: got %0d early completions expected 0", spurious); end
    wait_valid(got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL stale_valid: got timeout expected out_valid"); end
    checks++; if (out_product !== 8'd42) begin errors++; $display("[TB] FAIL stale_product: got %0d expected 42", out_product); end
    checks++; if (out_sum !== 10'd42) begin errors++; $display("[TB] FAIL stale_sum: got %0d expected 42", out_sum); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    stale_mode = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    bit got;
    int seen;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_pair(4'd5, 4'd5, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_push%0d: got timeout expected accept", i); end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_start !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rst_abandon: got %0d active cycles expected 0", seen); end
    push_pair(4'd4, 4'd4, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_push_new: got timeout expected accept"); end
    wait_valid(got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL rst_valid: got timeout expected out_valid"); end
    checks++; if (out_sum !== 10'd16) begin errors++; $display("[TB] FAIL rst_sum: got %0d expected 16", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf: got %b expected 0", out_ovf); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    mul_done    = 1'b0;
    mul_product = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_group_sum;
    test_overflow;
    test_back_to_back;
    test_stale_done;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
- Upstream feeder and downstream collector for the 4-bit sequential multiplier (`seq_multiplier`).
- Buffers operand pairs from a valid/ready producer in a small FIFO and issues them to the multiplier one at a time with a one-cycle start pulse.
- Captures each product when the multiplier signals done, keeps a running sum across a group of pairs, and presents product, sum and group-end to a valid/ready consumer.
- Turns the multiplier's start/done protocol into a streaming dot-product front end.

Parameters:
- W, 4: operand width; product width is 2*W.
- DEPTH, 4: operand FIFO depth; must be a power of 2, at least 2.
- ACC_W, 10: running-sum width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO not full
- in_a  in  W  multiplicand
- in_b  in  W  multiplier
- in_last  in  1  pair ends a group
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  W  operand A to multiplier
- mul_b  out  W  operand B to multiplier
- mul_product  in  2W  multiplier product
- mul_done  in  1  multiplier done (level or pulse)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_product  out  2W  product of current pair
- out_sum  out  ACC_W  running sum including current product
- out_last  out  1  copy of the pair's in_last
- out_ovf  out  1  running sum wrapped in this group (sticky)

Behaviour:
Reset:
- reset low clears all registers immediately: FIFO empty, state IDLE, accumulator 0, overflow flag 0.
- All outputs read 0 during reset, except in_ready, which reads 1.
- Reset mid-operation abandons the pair in flight and all buffered pairs; nothing is emitted for them.

FIFO:
- Push when in_valid && in_ready.
- in_ready = !full, computed from registered state; a pop in the same cycle does not raise in_ready until the next cycle.
- Push while empty is allowed; the pair can be popped no earlier than the next cycle.
- Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.

FSM:
- IDLE: if FIFO not empty, pop head into the mul_a/mul_b/last registers, go to START.
- START: mul_start = 1 for exactly this cycle, go to WAIT. mul_a and mul_b stay stable from START until leaving WAIT.
- WAIT: done is detected as the rising edge mul_done && !done_q, where done_q is mul_done registered. A done level left over from the previous operation is therefore ignored.
- On a detected done edge:
  - out_product <= mul_product.
  - sum = acc + zero-extended product, mod 2^ACC_W; carry out sets the sticky ovf.
  - acc <= sum; out_sum <= sum.
  - out_last <= last; out_valid <= 1; go to OUT.
- OUT: hold all out_* stable while out_ready is low. On out_ready:
  - out_valid <= 0.
  - If out_last, clear acc and ovf.
  - Go to IDLE.

Timing and flow:
- Minimum gap between successive mul_start pulses is 4 cycles plus the multiplier latency.
- Back-to-back groups are supported: the first pair of the next group starts from acc = 0.
- A product of 0 is handled normally and still produces an output beat.
- Upstream may keep filling the FIFO while WAIT/OUT is stalled.

Decomposition:
- Package mult_seq_pkg:
  - state typedef {IDLE, START, WAIT, OUT}
  - default W, DEPTH and ACC_W constants
  - PROD_W = 2*W
- One sub-module: mult_operand_fifo, a parameterised sync FIFO with async active-low reset carrying {last, a, b}, exposing push/pop/full/empty.

Test Plan:
- Basic single pair: reset low 2 cycles, push (3,5,last=1) → exactly one mul_start pulse with mul_a=3, mul_b=5. After done, out_valid with out_product=15, out_sum=15, out_last=1, out_ovf=0.
- Group sum: push (15,15,0), (10,0,0), (2,7,1) → products 225, 0, 14 and sums 225, 225, 239. out_last is 1 only on the third beat. A following (1,1,1) gives out_sum=1.
- Overflow: five pairs (15,15), last on the fifth → sums 225, 450, 675, 900, 101 (1125 mod 1024). out_ovf=1 on the fifth beat and 0 on the next group.
- Backpressure and FIFO full:
  - Hold out_ready=0 with the multiplier stalled and push continuously → in_ready drops after DEPTH pairs are buffered beyond the one in flight.
  - out_* stay stable; no further mul_start until out_ready=1.
  - Order of the products is preserved.
- Stale done: keep mul_done high after an operation → no spurious completion. The next pair completes only on a fresh rising edge.
- Reset mid-WAIT: assert reset during WAIT with 2 pairs queued → out_valid=0, in_ready=1, no output after release. A new push (4,4,1) gives out_sum=16.
